// File: rtl/ravenoc_pkg.sv
// Shared NI types: CSR request/response bundles and
// the CSR scheduler state and grant encodings.
package ravenoc_pkg;

  localparam int CsrAddrWidth    = 16;
  localparam int CsrSchedTimeout = 16;

  typedef struct packed {
    logic                    valid;
    logic                    rd_or_wr;
    logic [CsrAddrWidth-1:0] addr;
    logic [31:0]             data_in;
  } s_csr_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] data_out;
  } s_csr_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD_CAPT,
    ST_WR_RESP,
    ST_RD_RESP
  } csr_sched_st_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } csr_grant_t;

endpackage

// File: rtl/csr_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the
// side not granted last wins.
module csr_rr_arb2
  import ravenoc_pkg::*;
(
  input  logic clk_axi,
  input  logic arst_axi,
  input  logic req_wr,
  input  logic req_rd,
  input  logic update_en,
  output logic gnt_wr,
  output logic gnt_rd
);

  csr_grant_t last_grant;

  // Grant decision from current requests and history
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (req_wr && req_rd) begin
      gnt_rd = (last_grant == GNT_WR);
      gnt_wr = (last_grant == GNT_RD);
    end else begin
      gnt_wr = req_wr;
      gnt_rd = req_rd;
    end
  end

  // Remember which side won the last accepted grant
  always_ff @(posedge clk_axi) begin
    if (arst_axi) begin
      last_grant <= GNT_WR;
    end else if (update_en && (gnt_wr || gnt_rd)) begin
      last_grant <= gnt_wr ? GNT_WR : GNT_RD;
    end
  end

endmodule

// File: rtl/axi_csr_sched.sv
// Shares the CSR request port between the AXI write
// and read paths, one transaction in flight at a time.
module axi_csr_sched
  import ravenoc_pkg::*;
#(
  parameter int TimeoutCycles = CsrSchedTimeout
) (
  input  logic                    clk_axi,
  input  logic                    arst_axi,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [CsrAddrWidth-1:0] wr_addr_i,
  input  logic [31:0]             wr_data_i,
  output logic                    wr_resp_valid_o,
  input  logic                    wr_resp_ready_i,
  output logic                    wr_resp_err_o,
  input  logic                    rd_valid_i,
  output logic                    rd_ready_o,
  input  logic [CsrAddrWidth-1:0] rd_addr_i,
  output logic                    rd_resp_valid_o,
  input  logic                    rd_resp_ready_i,
  output logic [31:0]             rd_resp_data_o,
  output logic                    rd_resp_err_o,
  output s_csr_req_t              csr_req_o,
  input  s_csr_resp_t             csr_resp_i
);

  localparam int CntW = $clog2(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'(TimeoutCycles - 1);

  csr_sched_st_t   state;
  logic [CntW-1:0] to_cnt;
  logic            is_wr;
  logic            idle;
  logic            gnt_wr;
  logic            gnt_rd;

  assign idle = (state == ST_IDLE) && !arst_axi;

  csr_rr_arb2 u_arb (
    .clk_axi   (clk_axi),
    .arst_axi  (arst_axi),
    .req_wr    (wr_valid_i && idle),
    .req_rd    (rd_valid_i && idle),
    .update_en (idle),
    .gnt_wr    (gnt_wr),
    .gnt_rd    (gnt_rd)
  );

  assign wr_ready_o = gnt_wr;
  assign rd_ready_o = gnt_rd;

  // Transaction FSM with registered request/response
  always_ff @(posedge clk_axi) begin
    if (arst_axi) begin
      state           <= ST_IDLE;
      to_cnt          <= '0;
      is_wr           <= 1'b0;
      csr_req_o       <= '0;
      wr_resp_valid_o <= 1'b0;
      wr_resp_err_o   <= 1'b0;
      rd_resp_valid_o <= 1'b0;
      rd_resp_err_o   <= 1'b0;
      rd_resp_data_o  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gnt_wr || gnt_rd) begin
            is_wr              <= gnt_wr;
            csr_req_o.valid    <= 1'b1;
            csr_req_o.rd_or_wr <= gnt_wr;
            csr_req_o.addr     <= gnt_wr ? wr_addr_i
                                         : rd_addr_i;
            csr_req_o.data_in  <= gnt_wr ? wr_data_i
                                         : '0;
            to_cnt             <= '0;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (csr_resp_i.ready) begin
            csr_req_o <= '0;
            if (is_wr) begin
              wr_resp_valid_o <= 1'b1;
              wr_resp_err_o   <= csr_resp_i.error;
              state           <= ST_WR_RESP;
            end else begin
              state <= ST_RD_CAPT;
            end
          end else if (to_cnt == CntLast) begin
            csr_req_o <= '0;
            if (is_wr) begin
              wr_resp_valid_o <= 1'b1;
              wr_resp_err_o   <= 1'b1;
              state           <= ST_WR_RESP;
            end else begin
              rd_resp_valid_o <= 1'b1;
              rd_resp_err_o   <= 1'b1;
              rd_resp_data_o  <= '0;
              state           <= ST_RD_RESP;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RD_CAPT: begin
          rd_resp_valid_o <= 1'b1;
          rd_resp_err_o   <= csr_resp_i.error;
          rd_resp_data_o  <= csr_resp_i.error
                             ? '0 : csr_resp_i.data_out;
          state           <= ST_RD_RESP;
        end
        ST_WR_RESP: begin
          if (wr_resp_ready_i) begin
            wr_resp_valid_o <= 1'b0;
            wr_resp_err_o   <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        ST_RD_RESP: begin
          if (rd_resp_ready_i) begin
            rd_resp_valid_o <= 1'b0;
            rd_resp_err_o   <= 1'b0;
            rd_resp_data_o  <= '0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_csr_sched.sv
// Bench for axi_csr_sched: directed timing cases then
// random traffic against a transaction-level model.
module tb_axi_csr_sched;
  import ravenoc_pkg::*;

  logic        clk_axi = 1'b0;
  logic        arst_axi;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [15:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic        wr_resp_valid_o;
  logic        wr_resp_ready_i;
  logic        wr_resp_err_o;
  logic        rd_valid_i;
  logic        rd_ready_o;
  logic [15:0] rd_addr_i;
  logic        rd_resp_valid_o;
  logic        rd_resp_ready_i;
  logic [31:0] rd_resp_data_o;
  logic        rd_resp_err_o;
  s_csr_req_t  csr_req_o;
  s_csr_resp_t csr_resp_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_axi = ~clk_axi;

  axi_csr_sched #(.TimeoutCycles(16)) dut (
    .clk_axi         (clk_axi),
    .arst_axi        (arst_axi),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .wr_resp_valid_o (wr_resp_valid_o),
    .wr_resp_ready_i (wr_resp_ready_i),
    .wr_resp_err_o   (wr_resp_err_o),
    .rd_valid_i      (rd_valid_i),
    .rd_ready_o      (rd_ready_o),
    .rd_addr_i       (rd_addr_i),
    .rd_resp_valid_o (rd_resp_valid_o),
    .rd_resp_ready_i (rd_resp_ready_i),
    .rd_resp_data_o  (rd_resp_data_o),
    .rd_resp_err_o   (rd_resp_err_o),
    .csr_req_o       (csr_req_o),
    .csr_resp_i      (csr_resp_i)
  );

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_axi);
    #1;
  endtask

  // CSR map: 0 = read-only version, 1..5 = R/W, 6..7 unmapped
  function automatic bit rd_ok(logic [15:0] a);
    return a < 16'd6;
  endfunction

  function automatic bit wr_ok(logic [15:0] a);
    return (a >= 16'd1) && (a < 16'd6);
  endfunction

  logic [31:0] bank_mem [8];
  logic [31:0] ref_mem  [8];

  // model state
  bit          busy;
  bit          cur_wr;
  logic [15:0] cur_addr;
  logic [31:0] cur_data;
  bit          exp_err;
  logic [31:0] exp_data;
  bit          lg_rd;
  int          busy_cyc;

  // CSR bank behaviour
  int          wait_cnt   = 0;
  int          bank_stall = 0;
  bit          bank_rand  = 1'b0;
  bit          capt_pend  = 1'b0;
  bit          capt_err;
  logic [31:0] capt_data;

  always @(negedge clk_axi) begin
    csr_resp_i.ready    = 1'b0;
    csr_resp_i.error    = 1'($urandom);
    csr_resp_i.data_out = $urandom;
    if (capt_pend) begin
      csr_resp_i.error    = capt_err;
      csr_resp_i.data_out = capt_data;
      capt_pend           = 1'b0;
    end
    if (csr_req_o.valid === 1'b1) begin
      if (bank_rand && wait_cnt == 0 && busy) begin
        chk("req_dir", csr_req_o.rd_or_wr, cur_wr);
        chk("req_addr", csr_req_o.addr, cur_addr);
        chk("req_data", csr_req_o.data_in,
            cur_wr ? cur_data : 32'h0);
      end
      if (wait_cnt >= bank_stall) begin
        wait_cnt         = 0;
        csr_resp_i.ready = 1'b1;
        if (bank_rand) bank_stall = $urandom_range(0, 3);
        if (csr_req_o.rd_or_wr) begin
          csr_resp_i.error = !wr_ok(csr_req_o.addr);
          if (wr_ok(csr_req_o.addr))
            bank_mem[csr_req_o.addr[2:0]] =
              csr_req_o.data_in;
        end else begin
          capt_pend = 1'b1;
          capt_err  = !rd_ok(csr_req_o.addr);
          if (capt_err)
            capt_data = $urandom;
          else if (csr_req_o.addr == 16'd0)
            capt_data = 32'h1234_5678;
          else
            capt_data = bank_mem[csr_req_o.addr[2:0]];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk_rst(string t);
    chk({t, "_wrdy"}, wr_ready_o, 0);
    chk({t, "_rrdy"}, rd_ready_o, 0);
    chk({t, "_wrv"}, wr_resp_valid_o, 0);
    chk({t, "_wre"}, wr_resp_err_o, 0);
    chk({t, "_rrv"}, rd_resp_valid_o, 0);
    chk({t, "_rre"}, rd_resp_err_o, 0);
    chk({t, "_rrd"}, rd_resp_data_o, 0);
    chk({t, "_req"}, csr_req_o, 0);
  endtask

  int  nv;
  int  ng;
  bit  exp_rd;
  bit  ew;
  bit  er;

  initial begin
    for (int a = 0; a < 8; a++) bank_mem[a] = 32'h0;
    arst_axi        = 1'b1;
    wr_valid_i      = 1'b0;
    wr_addr_i       = '0;
    wr_data_i       = '0;
    wr_resp_ready_i = 1'b0;
    rd_valid_i      = 1'b0;
    rd_addr_i       = '0;
    rd_resp_ready_i = 1'b0;
    busy            = 1'b0;
    repeat (3) tick();
    chk_rst("rst");
    arst_axi = 1'b0;
    tick();

    // write 0x3 to IRQ mux offset
    wr_valid_i = 1'b1;
    wr_addr_i  = 16'd2;
    wr_data_i  = 32'h3;
    #1;
    chk("w_rdy", wr_ready_o, 1);
    chk("w_rrdy", rd_ready_o, 0);
    tick();
    wr_valid_i = 1'b0;
    chk("w_v1", csr_req_o.valid, 1);
    chk("w_dir", csr_req_o.rd_or_wr, 1);
    chk("w_din", csr_req_o.data_in, 3);
    chk("w_addr", csr_req_o.addr, 2);
    chk("w_rspv_n1", wr_resp_valid_o, 0);
    tick();
    chk("w_v2", csr_req_o.valid, 0);
    chk("w_rspv", wr_resp_valid_o, 1);
    chk("w_err", wr_resp_err_o, 0);
    wr_resp_ready_i = 1'b1;
    tick();
    wr_resp_ready_i = 1'b0;
    chk("w_rspv_clr", wr_resp_valid_o, 0);

    // read version, then response backpressure
    rd_valid_i = 1'b1;
    rd_addr_i  = 16'd0;
    #1;
    chk("r_rdy", rd_ready_o, 1);
    tick();
    rd_valid_i = 1'b0;
    chk("r_v1", csr_req_o.valid, 1);
    chk("r_dir", csr_req_o.rd_or_wr, 0);
    chk("r_din", csr_req_o.data_in, 0);
    tick();
    chk("r_v2", csr_req_o.valid, 0);
    chk("r_rspv_n2", rd_resp_valid_o, 0);
    tick();
    chk("r_rspv", rd_resp_valid_o, 1);
    chk("r_data", rd_resp_data_o, 32'h1234_5678);
    chk("r_err", rd_resp_err_o, 0);
    wr_valid_i = 1'b1;
    wr_addr_i  = 16'd0;
    wr_data_i  = 32'hdead;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_wrdy", wr_ready_o, 0);
      chk("bp_v", rd_resp_valid_o, 1);
      chk("bp_data", rd_resp_data_o, 32'h1234_5678);
      chk("bp_req", csr_req_o, 0);
      tick();
    end
    rd_resp_ready_i = 1'b1;
    #1;
    chk("bp_wrdy_hs", wr_ready_o, 0);
    tick();
    rd_resp_ready_i = 1'b0;
    #1;
    chk("b2b_wrdy", wr_ready_o, 1);
    chk("b2b_rrv", rd_resp_valid_o, 0);
    tick();
    wr_valid_i = 1'b0;
    chk("ro_v", csr_req_o.valid, 1);
    tick();
    chk("ro_rspv", wr_resp_valid_o, 1);
    chk("ro_err", wr_resp_err_o, 1);
    wr_resp_ready_i = 1'b1;
    tick();
    wr_resp_ready_i = 1'b0;

    // unmapped read
    rd_valid_i = 1'b1;
    rd_addr_i  = 16'd7;
    #1;
    chk("um_rdy", rd_ready_o, 1);
    tick();
    rd_valid_i = 1'b0;
    tick();
    tick();
    chk("um_rspv", rd_resp_valid_o, 1);
    chk("um_err", rd_resp_err_o, 1);
    chk("um_data", rd_resp_data_o, 0);
    rd_resp_ready_i = 1'b1;
    tick();
    rd_resp_ready_i = 1'b0;

    // tie after reset, then sustained alternation
    arst_axi = 1'b1;
    tick();
    arst_axi        = 1'b0;
    wr_valid_i      = 1'b1;
    wr_addr_i       = 16'd3;
    wr_data_i       = 32'h0a0a_0a0a;
    rd_valid_i      = 1'b1;
    rd_addr_i       = 16'd3;
    wr_resp_ready_i = 1'b1;
    rd_resp_ready_i = 1'b1;
    ng     = 0;
    exp_rd = 1'b1;
    for (int i = 0; i < 200 && ng < 8; i++) begin
      #1;
      if (wr_ready_o || rd_ready_o) begin
        chk("alt_rd", rd_ready_o, exp_rd);
        chk("alt_wr", wr_ready_o, !exp_rd);
        exp_rd = !exp_rd;
        ng++;
      end
      tick();
    end
    chk("alt_cnt", ng, 8);
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
    repeat (8) tick();
    wr_resp_ready_i = 1'b0;
    rd_resp_ready_i = 1'b0;
    chk("alt_quiet", csr_req_o, 0);

    // write timeout
    bank_stall = 100;
    wr_valid_i = 1'b1;
    wr_addr_i  = 16'd3;
    wr_data_i  = 32'h55;
    #1;
    chk("tw_rdy", wr_ready_o, 1);
    tick();
    wr_valid_i = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (!csr_req_o.valid) break;
      nv++;
      tick();
    end
    chk("tw_len", nv, 16);
    chk("tw_rspv", wr_resp_valid_o, 1);
    chk("tw_err", wr_resp_err_o, 1);
    chk("tw_req", csr_req_o, 0);
    wr_resp_ready_i = 1'b1;
    tick();
    wr_resp_ready_i = 1'b0;

    // read timeout
    rd_valid_i = 1'b1;
    rd_addr_i  = 16'd1;
    tick();
    rd_valid_i = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (!csr_req_o.valid) break;
      nv++;
      tick();
    end
    chk("tr_len", nv, 16);
    chk("tr_rspv", rd_resp_valid_o, 1);
    chk("tr_err", rd_resp_err_o, 1);
    chk("tr_data", rd_resp_data_o, 0);
    rd_resp_ready_i = 1'b1;
    tick();
    rd_resp_ready_i = 1'b0;

    // reset in the middle of ISSUE
    rd_valid_i = 1'b1;
    rd_addr_i  = 16'd2;
    tick();
    rd_valid_i = 1'b0;
    tick();
    tick();
    chk("mid_v", csr_req_o.valid, 1);
    arst_axi = 1'b1;
    tick();
    chk_rst("mid");
    arst_axi   = 1'b0;
    bank_stall = 0;
    tick();
    chk("mid_post", csr_req_o, 0);

    // random traffic against the model
    for (int a = 0; a < 8; a++) ref_mem[a] = bank_mem[a];
    bank_rand = 1'b1;
    lg_rd     = 1'b0;
    busy      = 1'b0;
    busy_cyc  = 0;
    repeat (3000) begin
      tick();
      wr_valid_i      = ($urandom_range(0, 3) != 0);
      wr_addr_i       = 16'($urandom_range(0, 7));
      wr_data_i       = $urandom;
      rd_valid_i      = ($urandom_range(0, 3) != 0);
      rd_addr_i       = 16'($urandom_range(0, 7));
      wr_resp_ready_i = 1'($urandom_range(0, 1));
      rd_resp_ready_i = 1'($urandom_range(0, 1));
      #1;
      ew = !busy && wr_valid_i && (!rd_valid_i || lg_rd);
      er = !busy && rd_valid_i && (!wr_valid_i || !lg_rd);
      chk("rnd_wrdy", wr_ready_o, ew);
      chk("rnd_rrdy", rd_ready_o, er);
      chk("rnd_wrv", wr_resp_valid_o && !(busy && cur_wr), 0);
      chk("rnd_rrv", rd_resp_valid_o && !(busy && !cur_wr), 0);
      if (!csr_req_o.valid) chk("rnd_req0", csr_req_o, 0);
      if (busy) begin
        busy_cyc++;
        if (cur_wr && wr_resp_valid_o) begin
          chk("rnd_werr", wr_resp_err_o, exp_err);
          if (wr_resp_ready_i) busy = 1'b0;
        end
        if (!cur_wr && rd_resp_valid_o) begin
          chk("rnd_rerr", rd_resp_err_o, exp_err);
          chk("rnd_rdata", rd_resp_data_o, exp_data);
          if (rd_resp_ready_i) busy = 1'b0;
        end
        if (busy_cyc > 60) begin
          chk("rnd_hang", busy_cyc, 0);
          busy = 1'b0;
        end
      end
      if (ew) begin
        cur_wr   = 1'b1;
        cur_addr = wr_addr_i;
        cur_data = wr_data_i;
        exp_err  = !wr_ok(wr_addr_i);
        if (!exp_err) ref_mem[wr_addr_i[2:0]] = wr_data_i;
        lg_rd    = 1'b0;
        busy     = 1'b1;
        busy_cyc = 0;
      end else if (er) begin
        cur_wr   = 1'b0;
        cur_addr = rd_addr_i;
        cur_data = 32'h0;
        exp_err  = !rd_ok(rd_addr_i);
        if (exp_err)
          exp_data = 32'h0;
        else if (rd_addr_i == 16'd0)
          exp_data = 32'h1234_5678;
        else
          exp_data = ref_mem[rd_addr_i[2:0]];
        lg_rd    = 1'b1;
        busy     = 1'b1;
        busy_cyc = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
